alarm_bank: RTL and testbench
=============================

ALARM_BANK -- requirements
Module: alarm_bank

Interface
REQ-001 SHALL have parameter NUM_ALM, default 4, number of independent alarm channels (1..8).
REQ-002 SHALL have parameter RING_SEC, default 30, seconds a channel rings before auto-stop (1..255).
REQ-003 SHALL have parameter SNOOZE_SEC, default 60, snooze length in seconds (1..1023).
REQ-004 SHALL have port: clk  input  1  system clock.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: tick_1hz  input  1  one-clk-wide pulse, once per second.
REQ-007 SHALL have port: time_bcd  input  24  current time {hour1,hour0,min1,min0,sec1,sec0}, 4-bit BCD each.
REQ-008 SHALL have port: wr_en  input  1  write setpoint/arm for channel wr_sel this cycle.
REQ-009 SHALL have port: wr_sel  input  3  target channel index.
REQ-010 SHALL have port: wr_bcd  input  24  setpoint, same packing as time_bcd.
REQ-011 SHALL have port: wr_arm  input  1  arm (1) or disarm (0) on write.
REQ-012 SHALL have port: ack  input  1  dismiss level, sampled every clk.
REQ-013 SHALL have port: snooze  input  1  snooze request, sampled every clk.
REQ-014 SHALL have port: rd_sel  input  3  channel selected for readback.
REQ-015 SHALL have port: rd_bcd  output  24  stored setpoint of channel rd_sel, combinational.
REQ-016 SHALL have port: armed  output  NUM_ALM  per-channel state != IDLE.
REQ-017 SHALL have port: ring  output  NUM_ALM  per-channel state == RINGING, registered.
REQ-018 SHALL have port: any_ring  output  1  OR of ring.
REQ-019 SHALL have port: wr_err  output  1  one-cycle pulse, rejected write.

Function
REQ-020 Each channel SHALL run an FSM with states IDLE, ARMED, RINGING, SNOOZED, plus an 8-bit ring counter and a 10-bit snooze counter.
REQ-021 Write validity SHALL require every digit <= 9, hours <= 23, minutes <= 59, seconds <= 59, and wr_sel < NUM_ALM; otherwise write ignored and wr_err pulses the next cycle.
REQ-022 A valid write SHALL store the setpoint, clear both counters, and set state ARMED if wr_arm=1, else IDLE; the write has top priority for that channel in that cycle.
REQ-023 ARMED -> RINGING SHALL occur on a cycle with tick_1hz=1 and time_bcd == setpoint; ring counter loads RING_SEC; ring visible the following cycle.
REQ-024 No match SHALL be evaluated without tick_1hz; several channels matching on the same tick all ring.
REQ-025 RINGING: each tick SHALL decrement the ring counter; tick with counter==1 -> ARMED (auto-stop after exactly RING_SEC ticks).
REQ-026 RINGING with ack=1 SHALL -> ARMED next cycle, for every ringing channel.
REQ-027 RINGING with snooze=1 and ack=0 SHALL -> SNOOZED; snooze counter loads SNOOZE_SEC.
REQ-028 SNOOZED: each tick SHALL decrement; tick with counter==1 -> RINGING with ring counter reloaded to RING_SEC.
REQ-029 SNOOZED with ack=1 SHALL -> ARMED; snooze ignored in SNOOZED, ARMED, IDLE.
REQ-030 Priority per channel per cycle SHALL be: valid write > ack > snooze > tick-driven count/match.
REQ-031 A match tick occurring while RINGING or SNOOZED SHALL NOT restart counters.
REQ-032 Channels with index >= NUM_ALM SHALL not exist; rd_sel out of range returns 24'h0.

Reset
REQ-033 rst_n low SHALL immediately force all setpoints to 24'h0, all states IDLE, counters 0, ring/armed/any_ring/wr_err 0, including mid-ring or mid-snooze.
REQ-034 After rst_n rises, first tick SHALL be processed normally; no alarm fires until a valid armed write.

Verification
REQ-035 Write ch1 12:30:00 armed; drive time_bcd 12:29:59 then 12:30:00 with ticks -> ring[1]=1 one cycle after the 12:30:00 tick, low after 30 further ticks, armed[1] remains 1.
REQ-036 Ch0 ringing, snooze=1 for one cycle -> ring[0]=0; after 60 ticks ring[0]=1 again; ack -> ring[0]=0, state ARMED.
REQ-037 Write ch2 24:00:00 or 12:6A:00 -> wr_err pulse, rd_bcd (rd_sel=2) unchanged, armed[2] unchanged.
REQ-038 Ch0 and ch3 both set 07:00:00 armed -> both ring on the same cycle, any_ring=1; single ack clears both.
REQ-039 ack and snooze asserted together while ringing -> ARMED, no snooze; valid write to matching channel on match tick -> no ring.
REQ-040 rst_n low mid-ring -> ring, armed, any_ring 0 immediately without waiting for clk; rd_bcd=0 for all channels.

Source files
------------

// File: rtl/alarm_bank.sv
// Bank of NUM_ALM independent BCD-time alarm channels with ring, snooze and ack.
// Each channel holds a setpoint, a four-state FSM, a ring counter and a snooze counter.
module alarm_bank #(
    parameter int unsigned NUM_ALM    = 4,
    parameter int unsigned RING_SEC   = 30,
    parameter int unsigned SNOOZE_SEC = 60
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_1hz,
    input  logic [23:0]        time_bcd,
    input  logic               wr_en,
    input  logic [2:0]         wr_sel,
    input  logic [23:0]        wr_bcd,
    input  logic               wr_arm,
    input  logic               ack,
    input  logic               snooze,
    input  logic [2:0]         rd_sel,
    output logic [23:0]        rd_bcd,
    output logic [NUM_ALM-1:0] armed,
    output logic [NUM_ALM-1:0] ring,
    output logic               any_ring,
    output logic               wr_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RING,
        S_SNOOZE
    } state_t;

    state_t      r_state [NUM_ALM];
    logic [23:0] r_set   [NUM_ALM];
    logic [7:0]  r_rcnt  [NUM_ALM];
    logic [9:0]  r_scnt  [NUM_ALM];
    logic        r_wr_err;

    logic               w_dig_ok;
    logic               w_hour_ok;
    logic               w_min_ok;
    logic               w_sec_ok;
    logic               w_sel_ok;
    logic               w_valid;
    logic [NUM_ALM-1:0] w_wr_hit;

    always_comb begin
        w_dig_ok = 1'b1;
        for (int unsigned k = 0; k < 6; k++) begin
            if (wr_bcd[4*k +: 4] > 4'd9) w_dig_ok = 1'b0;
        end
        w_hour_ok = (wr_bcd[23:20] < 4'd2) ||
                    ((wr_bcd[23:20] == 4'd2) && (wr_bcd[19:16] <= 4'd3));
        w_min_ok  = (wr_bcd[15:12] <= 4'd5);
        w_sec_ok  = (wr_bcd[7:4] <= 4'd5);
        w_sel_ok  = ({29'd0, wr_sel} < NUM_ALM);
        w_valid   = w_dig_ok && w_hour_ok && w_min_ok && w_sec_ok && w_sel_ok;
        w_wr_hit  = '0;
        for (int unsigned i = 0; i < NUM_ALM; i++) begin
            w_wr_hit[i] = wr_en && w_valid && ({29'd0, wr_sel} == i);
        end
    end

    // Per-channel priority: valid write, then ack, then snooze, then tick activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_err <= 1'b0;
            for (int unsigned i = 0; i < NUM_ALM; i++) begin
                r_state[i] <= S_IDLE;
                r_set[i]   <= '0;
                r_rcnt[i]  <= '0;
                r_scnt[i]  <= '0;
            end
        end else begin
            r_wr_err <= wr_en && !w_valid;
            for (int unsigned i = 0; i < NUM_ALM; i++) begin
                if (w_wr_hit[i]) begin
                    r_set[i]   <= wr_bcd;
                    r_rcnt[i]  <= '0;
                    r_scnt[i]  <= '0;
                    r_state[i] <= wr_arm ? S_ARMED : S_IDLE;
                end else begin
                    case (r_state[i])
                        S_ARMED: begin
                            if (tick_1hz && (time_bcd == r_set[i])) begin
                                r_state[i] <= S_RING;
                                r_rcnt[i]  <= 8'(RING_SEC);
                            end
                        end
                        S_RING: begin
                            if (ack) begin
                                r_state[i] <= S_ARMED;
                                r_rcnt[i]  <= '0;
                            end else if (snooze) begin
                                r_state[i] <= S_SNOOZE;
                                r_rcnt[i]  <= '0;
                                r_scnt[i]  <= 10'(SNOOZE_SEC);
                            end else if (tick_1hz) begin
                                if (r_rcnt[i] == 8'd1) r_state[i] <= S_ARMED;
                                r_rcnt[i] <= r_rcnt[i] - 8'd1;
                            end
                        end
                        S_SNOOZE: begin
                            if (ack) begin
                                r_state[i] <= S_ARMED;
                                r_scnt[i]  <= '0;
                            end else if (tick_1hz) begin
                                if (r_scnt[i] == 10'd1) begin
                                    r_state[i] <= S_RING;
                                    r_rcnt[i]  <= 8'(RING_SEC);
                                end
                                r_scnt[i] <= r_scnt[i] - 10'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        ring   = '0;
        armed  = '0;
        rd_bcd = '0;
        for (int unsigned i = 0; i < NUM_ALM; i++) begin
            ring[i]  = (r_state[i] == S_RING);
            armed[i] = (r_state[i] != S_IDLE);
            if ({29'd0, rd_sel} == i) rd_bcd = r_set[i];
        end
        any_ring = |ring;
        wr_err   = r_wr_err;
    end

endmodule

// File: tb/tb_alarm_bank.sv
// Directed self-checking bench for alarm_bank (default parameters: 4 channels, 30 s ring, 60 s snooze).
module tb_alarm_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick_1hz;
    logic [23:0] time_bcd;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [23:0] wr_bcd;
    logic        wr_arm;
    logic        ack;
    logic        snooze;
    logic [2:0]  rd_sel;
    logic [23:0] rd_bcd;
    logic [3:0]  armed;
    logic [3:0]  ring;
    logic        any_ring;
    logic        wr_err;

    int n_cmp = 0;
    int n_err = 0;

    alarm_bank #(.NUM_ALM(4), .RING_SEC(30), .SNOOZE_SEC(60)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_1hz (tick_1hz),
        .time_bcd (time_bcd),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_bcd   (wr_bcd),
        .wr_arm   (wr_arm),
        .ack      (ack),
        .snooze   (snooze),
        .rd_sel   (rd_sel),
        .rd_bcd   (rd_bcd),
        .armed    (armed),
        .ring     (ring),
        .any_ring (any_ring),
        .wr_err   (wr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] sel, input logic [23:0] bcd, input logic arm);
        wr_en  = 1'b1;
        wr_sel = sel;
        wr_bcd = bcd;
        wr_arm = arm;
        step();
        wr_en  = 1'b0;
    endtask

    task automatic tick1();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            tick1();
            step();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        tick_1hz = 1'b0;
        time_bcd = '0;
        wr_en    = 1'b0;
        wr_sel   = '0;
        wr_bcd   = '0;
        wr_arm   = 1'b0;
        ack      = 1'b0;
        snooze   = 1'b0;
        rd_sel   = '0;
        step();
        step();
        chk("rst_ring", 32'(ring), 32'h0);
        chk("rst_armed", 32'(armed), 32'h0);
        chk("rst_any", 32'(any_ring), 32'h0);
        chk("rst_wr_err", 32'(wr_err), 32'h0);
        chk("rst_rd", 32'(rd_bcd), 32'h0);
        rst_n = 1'b1;
        step();

        // Single channel ring and auto-stop
        wr(3'd1, 24'h123000, 1'b1);
        chk("w1_err", 32'(wr_err), 32'h0);
        chk("w1_armed", 32'(armed), 32'h2);
        rd_sel = 3'd1;
        #1;
        chk("w1_rd", 32'(rd_bcd), 32'h123000);
        time_bcd = 24'h123000;
        step();
        chk("no_tick_no_match", 32'(ring), 32'h0);
        time_bcd = 24'h122959;
        tick_n(1);
        chk("pre_match", 32'(ring), 32'h0);
        time_bcd = 24'h123000;
        tick1();
        chk("match_ring", 32'(ring), 32'h2);
        chk("match_any", 32'(any_ring), 32'h1);
        step();
        time_bcd = 24'h123001;
        tick_n(29);
        chk("ring_29", 32'(ring), 32'h2);
        tick_n(1);
        chk("ring_30_stop", 32'(ring), 32'h0);
        chk("ring_30_armed", 32'(armed), 32'h2);

        // Snooze then ack
        wr(3'd0, 24'h070000, 1'b1);
        time_bcd = 24'h070000;
        tick1();
        chk("ch0_ring", 32'(ring), 32'h1);
        step();
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        chk("snz_ring", 32'(ring), 32'h0);
        chk("snz_armed", 32'(armed), 32'h3);
        tick_n(59);
        chk("snz_59", 32'(ring), 32'h0);
        tick_n(1);
        chk("snz_60", 32'(ring), 32'h1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("ack_ring", 32'(ring), 32'h0);
        chk("ack_armed", 32'(armed), 32'h3);
        time_bcd = 24'h000000;

        // Write validation
        rd_sel = 3'd2;
        wr(3'd2, 24'h080000, 1'b1);
        chk("w2_err", 32'(wr_err), 32'h0);
        chk("w2_rd", 32'(rd_bcd), 32'h080000);
        wr(3'd2, 24'h240000, 1'b1);
        chk("bad_hour_err", 32'(wr_err), 32'h1);
        chk("bad_hour_rd", 32'(rd_bcd), 32'h080000);
        step();
        chk("err_pulse_end", 32'(wr_err), 32'h0);
        wr(3'd2, 24'h126A00, 1'b0);
        chk("bad_digit_err", 32'(wr_err), 32'h1);
        chk("bad_digit_rd", 32'(rd_bcd), 32'h080000);
        chk("bad_digit_armed", 32'(armed), 32'h7);
        wr(3'd5, 24'h010101, 1'b1);
        chk("bad_sel_err", 32'(wr_err), 32'h1);
        chk("bad_sel_armed", 32'(armed), 32'h7);
        wr(3'd2, 24'h235959, 1'b1);
        chk("max_time_err", 32'(wr_err), 32'h0);
        chk("max_time_rd", 32'(rd_bcd), 32'h235959);
        wr(3'd2, 24'h235959, 1'b0);
        chk("disarm", 32'(armed), 32'h3);
        rd_sel = 3'd5;
        #1;
        chk("rd_oor", 32'(rd_bcd), 32'h0);

        // Two channels on one tick, single ack, no restart on re-match
        wr(3'd0, 24'h070000, 1'b1);
        wr(3'd3, 24'h070000, 1'b1);
        chk("dual_armed", 32'(armed), 32'hB);
        time_bcd = 24'h070000;
        tick1();
        chk("dual_ring", 32'(ring), 32'h9);
        chk("dual_any", 32'(any_ring), 32'h1);
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("dual_ack", 32'(ring), 32'h0);
        chk("dual_ack_any", 32'(any_ring), 32'h0);
        tick_n(1);
        chk("rematch_ring", 32'(ring), 32'h9);
        tick_n(29);
        chk("norestart_29", 32'(ring), 32'h9);
        tick_n(1);
        chk("norestart_30", 32'(ring), 32'h0);
        chk("norestart_armed", 32'(armed), 32'hB);

        // ack beats snooze
        tick_n(1);
        chk("as_ring", 32'(ring), 32'h9);
        ack    = 1'b1;
        snooze = 1'b1;
        step();
        ack    = 1'b0;
        snooze = 1'b0;
        chk("as_cleared", 32'(ring), 32'h0);
        time_bcd = 24'h070001;
        tick_n(60);
        chk("as_no_snooze", 32'(ring), 32'h0);
        chk("as_armed", 32'(armed), 32'hB);

        // Write beats a match tick on the same channel
        time_bcd = 24'h123000;
        wr_en    = 1'b1;
        wr_sel   = 3'd1;
        wr_bcd   = 24'h123000;
        wr_arm   = 1'b1;
        tick_1hz = 1'b1;
        step();
        wr_en    = 1'b0;
        tick_1hz = 1'b0;
        chk("wr_on_tick_ring", 32'(ring), 32'h0);
        chk("wr_on_tick_err", 32'(wr_err), 32'h0);
        step();
        tick1();
        chk("after_wr_ring", 32'(ring), 32'h2);

        // Asynchronous reset while ringing
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ring", 32'(ring), 32'h0);
        chk("arst_armed", 32'(armed), 32'h0);
        chk("arst_any", 32'(any_ring), 32'h0);
        for (int c = 0; c < 8; c++) begin
            rd_sel = 3'(c);
            #0.5;
            chk($sformatf("arst_rd%0d", c), 32'(rd_bcd), 32'h0);
        end
        step();
        rst_n = 1'b1;
        step();
        tick_n(1);
        chk("post_rst_no_ring", 32'(ring), 32'h0);
        wr(3'd1, 24'h123000, 1'b1);
        tick1();
        chk("post_rst_ring", 32'(ring), 32'h2);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
